// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march BIST: FSM states and default geometry/pattern.
// Defaults describe a 16x8 RAM with a single-cycle registered read.
package ram_bist_pkg;

    localparam int         DEF_ADDR_W  = 4;
    localparam int         DEF_DATA_W  = 8;
    localparam logic [7:0] DEF_PATTERN = 8'hA5;
    localparam int         DEF_RD_LAT  = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ASC,
        RD_ASC,
        WR_INV,
        RD_DESC,
        DONE
    } state_t;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-check pipeline: carries each issued address/expected value RD_LAT+1 cycles
// alongside a registered copy of ram_dout, so the compare is a flop-to-flop path.
module ram_bist_cmp #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_vld,
    input  logic              issue_last,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_exp,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              cmp_vld,
    output logic              cmp_last,
    output logic              cmp_err,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic [DATA_W-1:0] cmp_data
);

    localparam int DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  last_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] exp_q  [DEPTH];
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q     <= {vld_q[DEPTH-2:0], issue_vld};
            last_q    <= {last_q[DEPTH-2:0], issue_last};
            addr_q[0] <= issue_addr;
            exp_q[0]  <= issue_exp;
            for (int i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
            dout_q <= ram_dout;
        end
    end

    assign cmp_vld  = vld_q[DEPTH-1];
    assign cmp_last = last_q[DEPTH-1];
    assign cmp_addr = addr_q[DEPTH-1];
    assign cmp_data = dout_q;
    assign cmp_err  = vld_q[DEPTH-1] && (dout_q != exp_q[DEPTH-1]);

endmodule

// File: rtl/ram_march_bist.sv
// March BIST for a single-port RAM: write PATTERN ascending, read ascending,
// write ~PATTERN ascending, read descending; stops at the first mismatch.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN),
    parameter int                RD_LAT  = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic              rd_issue, rd_issue_nxt;
    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_din_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;
    logic [ADDR_W-1:0] fail_addr_nxt;
    logic [DATA_W-1:0] fail_data_nxt;

    logic              issue_last;
    logic [DATA_W-1:0] issue_exp;
    logic              cmp_vld, cmp_last, cmp_err;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_data;

    assign issue_exp  = (state == RD_ASC) ? PATTERN : ~PATTERN;
    assign issue_last = (state == RD_ASC) ? (ram_addr == ADDR_MAX) : (ram_addr == '0);

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_vld  (rd_issue),
        .issue_last (issue_last),
        .issue_addr (ram_addr),
        .issue_exp  (issue_exp),
        .ram_dout   (ram_dout),
        .cmp_vld    (cmp_vld),
        .cmp_last   (cmp_last),
        .cmp_err    (cmp_err),
        .cmp_addr   (cmp_addr),
        .cmp_data   (cmp_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_issue  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_nxt;
            rd_issue  <= rd_issue_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_din   <= ram_din_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_addr <= fail_addr_nxt;
            fail_data <= fail_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rd_issue_nxt  = rd_issue;
        ram_we_nxt    = ram_we;
        ram_addr_nxt  = ram_addr;
        ram_din_nxt   = ram_din;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        fail_addr_nxt = fail_addr;
        fail_data_nxt = fail_data;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = WR_ASC;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    fail_addr_nxt = '0;
                    fail_data_nxt = '0;
                    ram_we_nxt    = 1'b1;
                    ram_addr_nxt  = '0;
                    ram_din_nxt   = PATTERN;
                end
            end
            WR_ASC: begin
                if (ram_addr == ADDR_MAX) begin
                    state_nxt    = RD_ASC;
                    ram_we_nxt   = 1'b0;
                    ram_addr_nxt = '0;
                    rd_issue_nxt = 1'b1;
                end else begin
                    ram_addr_nxt = ram_addr + ADDR_ONE;
                end
            end
            RD_ASC: begin
                // Address holds at the last value while the pipeline drains.
                if (rd_issue) begin
                    if (ram_addr == ADDR_MAX) rd_issue_nxt = 1'b0;
                    else                      ram_addr_nxt = ram_addr + ADDR_ONE;
                end
                if (cmp_vld && cmp_last && !cmp_err) begin
                    state_nxt    = WR_INV;
                    ram_we_nxt   = 1'b1;
                    ram_addr_nxt = '0;
                    ram_din_nxt  = ~PATTERN;
                end
            end
            WR_INV: begin
                if (ram_addr == ADDR_MAX) begin
                    state_nxt    = RD_DESC;
                    ram_we_nxt   = 1'b0;
                    ram_addr_nxt = ADDR_MAX;
                    rd_issue_nxt = 1'b1;
                end else begin
                    ram_addr_nxt = ram_addr + ADDR_ONE;
                end
            end
            RD_DESC: begin
                if (rd_issue) begin
                    if (ram_addr == '0) rd_issue_nxt = 1'b0;
                    else                ram_addr_nxt = ram_addr - ADDR_ONE;
                end
                if (cmp_vld && cmp_last && !cmp_err) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // First mismatch wins; results still in the pipeline are ignored in DONE.
        if ((state == RD_ASC || state == RD_DESC) && cmp_err) begin
            state_nxt     = DONE;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
            pass_nxt      = 1'b0;
            fail_addr_nxt = cmp_addr;
            fail_data_nxt = cmp_data;
            ram_we_nxt    = 1'b0;
            rd_issue_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist against a registered 16x8 RAM model with injectable faults.
// Expected results are queued at start; a monitor pops one on every rising edge of done.
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;

    typedef struct {
        string      name;
        int         edge_n;
        logic       pass;
        logic [3:0] fa;
        logic [7:0] fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fault_mode = 0;
    int   wr_in_done = 0;
    logic done_q = 1'b0;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_march_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
        if (fault_mode == 1 && a == 4'h6) return 8'hA4;
        if (fault_mode == 2 && a == 4'h0) return d | 8'h80;
        return d;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= faulty(ram_addr, mem[ram_addr]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one expectation per done rising edge.
    always @(negedge clk) begin
        if (done && ram_we) wr_in_done <= wr_in_done + 1;
        done_q <= done;
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_done_edge"}, 32'(cyc), 32'(e.edge_n));
                check({e.name, "_pass"}, 32'(pass), 32'(e.pass));
                check({e.name, "_fail_addr"}, 32'(fail_addr), 32'(e.fa));
                check({e.name, "_fail_data"}, 32'(fail_data), 32'(e.fd));
                check({e.name, "_busy_low"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue_start(input bit hold, output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic push_exp(input string name, input int edge_n, input logic p,
                            input logic [3:0] fa, input logic [7:0] fd);
        exp_t e;
        e.name = name; e.edge_n = edge_n; e.pass = p; e.fa = fa; e.fd = fd;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_edge(input int target);
        for (int i = 0; i < 400 && cyc < target; i++) @(negedge clk);
    endtask

    initial begin
        int t0;

        #1;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_fail_data", 32'(fail_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free: 16 + 18 + 16 + 18 edges.
        fault_mode = 0;
        issue_start(1'b0, t0);
        push_exp("clean", t0 + 68, 1'b1, 4'h0, 8'h00);
        check("clean_busy_after_start", 32'(busy), 32'd1);
        wait_done("clean");

        // Address 6 reads A4: read issued after edge 22, decided at edge 25.
        fault_mode = 1;
        issue_start(1'b0, t0);
        push_exp("stuck6", t0 + 25, 1'b0, 4'h6, 8'hA4);
        wait_done("stuck6");
        repeat (10) @(negedge clk);
        check("stuck6_fail_addr_held", 32'(fail_addr), 32'h6);
        check("stuck6_fail_data_held", 32'(fail_data), 32'hA4);
        check("stuck6_done_held", 32'(done), 32'd1);

        // Address 0 bit 7 stuck high: only the final RD_DESC compare fails.
        fault_mode = 2;
        issue_start(1'b0, t0);
        push_exp("bit7", t0 + 68, 1'b0, 4'h0, 8'hDA);
        wait_done("bit7");

        // Start re-pulsed while busy must not disturb timing.
        fault_mode = 0;
        issue_start(1'b0, t0);
        push_exp("restart_ignored", t0 + 68, 1'b1, 4'h0, 8'h00);
        wait_edge(t0 + 19);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_ignored");

        // Reset during WR_ASC aborts at once, then a fresh run passes.
        issue_start(1'b0, t0);
        wait_edge(t0 + 10);
        rst_n = 1'b0;
        #1;
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ram_addr", 32'(ram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_idle_done", 32'(done), 32'd0);
        issue_start(1'b0, t0);
        push_exp("after_rst", t0 + 68, 1'b1, 4'h0, 8'h00);
        wait_done("after_rst");

        // Start held high: restart at edge 69, second result at 69 + 68.
        issue_start(1'b1, t0);
        push_exp("held1", t0 + 68, 1'b1, 4'h0, 8'h00);
        push_exp("held2", t0 + 137, 1'b1, 4'h0, 8'h00);
        wait_edge(t0 + 69);
        check("held_done_dropped", 32'(done), 32'd0);
        check("held_busy_again", 32'(busy), 32'd1);
        wait_edge(t0 + 137);
        start = 1'b0;
        wait_done("held");

        check("no_writes_while_done", 32'(wr_in_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ram_march_bist.md
RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 Parameter: ADDR_W, default 4, RAM address width; depth = 2**ADDR_W.
REQ-002 Parameter: DATA_W, default 8, RAM data width.
REQ-003 Parameter: PATTERN, default 8'hA5, background data for the test.
REQ-004 Parameter: RD_LAT, default 1, RAM read latency: dout is valid RD_LAT cycles after the edge that samples addr.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock, shared with the RAM.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  level; sampled only in IDLE or DONE.
REQ-009 ram_we  out  1  RAM write enable.
REQ-010 ram_addr  out  ADDR_W  RAM address.
REQ-011 ram_din  out  DATA_W  RAM write data.
REQ-012 ram_dout  in  DATA_W  RAM read data.
REQ-013 busy  out  1  test in progress.
REQ-014 done  out  1  test finished; held until the next start.
REQ-015 pass  out  1  valid while done=1; 1 means no mismatch.
REQ-016 fail_addr  out  ADDR_W  address of the first mismatch; 0 if pass.
REQ-017 fail_data  out  DATA_W  data read at the first mismatch; 0 if pass.

Function
REQ-018 States: IDLE, WR_ASC, RD_ASC, WR_INV, RD_DESC, DONE. All outputs are registered.
REQ-019 IDLE/DONE with start=1 -> WR_ASC; clear done, pass, fail_addr and fail_data; set busy=1.
REQ-020 WR_ASC: ram_we=1, ram_din=PATTERN, address 0 up to depth-1 at one per cycle; after the last address -> RD_ASC.
REQ-021 RD_ASC: ram_we=0, address 0 up to depth-1 at one per cycle; expected value PATTERN.
REQ-022 WR_INV: ram_we=1, ram_din=~PATTERN, address 0 up to depth-1.
REQ-023 RD_DESC: ram_we=0, address depth-1 down to 0; expected value ~PATTERN.
REQ-024 Read phases: each issued address and its expected value SHALL be delayed RD_LAT+1 cycles.
REQ-025 Read phases: compare ram_dout at the matching cycle; the phase ends after the last compare, i.e. depth+RD_LAT+1 cycles per read phase.
REQ-026 First mismatch: latch fail_addr and fail_data, go to DONE with pass=0, and drop ram_we that cycle; no further compares.
REQ-027 Full pass with defaults: done=1 and pass=1 are visible after the 68th rising edge after the start-sampling edge (16+18+16+18).
REQ-028 Address counters SHALL wrap only at phase boundaries; no address outside 0..depth-1 is ever driven.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 start held high in DONE restarts the test on the next edge.
REQ-031 Mismatch on the final compare of RD_DESC (address 0) SHALL report fail_addr=0 with pass=0.
REQ-032 ram_din SHALL equal the last written value when ram_we=0.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0.
REQ-034 Reset mid-test SHALL abort with no further RAM writes; after release, the block waits in IDLE for start.

Structure
REQ-035 Package ram_bist_pkg SHALL hold the state enum and the default ADDR_W, DATA_W, PATTERN and RD_LAT.
REQ-036 Sub-module ram_bist_cmp SHALL hold the RD_LAT+1 delay line for address and expected value, plus the comparator.

Verification
REQ-037 Bench with a registered 16x8 RAM model, fault-free: start pulse -> done=1 and pass=1 at edge 68; fail_addr=0; fail_data=0.
REQ-038 Stuck-at fault, RAM[4'h6] reads 8'hA4: -> pass=0, fail_addr=4'h6, fail_data=8'hA4 during RD_ASC; no writes after the failure.
REQ-039 RAM[4'h0] bit 7 stuck at 1 (~A5=5A reads DA): -> passes RD_ASC, then fails at the end of RD_DESC with fail_addr=0 and fail_data=8'hDA.
REQ-040 start pulsed again at edge 20 while busy: ignored; done still at edge 68.
REQ-041 rst_n=0 at edge 10 during WR_ASC: -> ram_we=0 and busy=0 immediately; a new start gives a full 68-cycle pass.
REQ-042 start held high after done: -> restart next edge; done drops; second pass=1 after 68 more edges.
